// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared types and constants for the LED PWM scheduler.
// Holds the pattern mode enum, level width, rotate table and period helper.
package led_sched_pkg;

  localparam int LEVEL_W = 8;
  localparam int NCH     = 8;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ROTATE  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e  mode;
    level_t level;
  } cfg_t;

  // Channel 0 in the low byte: L[0..7] = 255,128,64,32,16,8,0,0
  localparam logic [NCH*LEVEL_W-1:0] ROT_INIT = {
    8'd0,  8'd0,  8'd8,   8'd16,
    8'd32, 8'd64, 8'd128, 8'd255
  };

  function automatic int period(
    input int clk_hz,
    input int pwm_hz
  );
    return clk_hz / pwm_hz;
  endfunction

endpackage

// File: rtl/led_duty_scale.sv
// led_duty_scale: combinational level -> duty, duty = (g*PERIOD) >> 8.
// Ports: level (8b in), duty (DUTY_W out). Macro LED_GAMMA_EN: g = level^2 >> 8.
module led_duty_scale
  import led_sched_pkg::*;
#(
  parameter int DUTY_W = 16,
  parameter int PERIOD = 16
) (
  input  logic [LEVEL_W-1:0] level,
  output logic [DUTY_W-1:0]  duty
);

  localparam int PROD_W = LEVEL_W + DUTY_W;

  level_t            g;
  logic [PROD_W-1:0] prod;

`ifdef LED_GAMMA_EN
  logic [2*LEVEL_W-1:0] sq;

  assign sq = {{LEVEL_W{1'b0}}, level}
            * {{LEVEL_W{1'b0}}, level};
  assign g  = LEVEL_W'(sq >> LEVEL_W);
`else
  assign g = level;
`endif

  // 255 * 2^DUTY_W still fits in PROD_W, so no bits are lost
  assign prod = PROD_W'(g) * PROD_W'(PERIOD);
  assign duty = DUTY_W'(prod >> LEVEL_W);

endmodule

// File: rtl/led_pwm_sched.sv
// led_pwm_sched: PWM period counter, step timer and pattern sequencer.
// Ports: clk, rst (sync high); cfg_valid/cfg_ready/cfg_mode/cfg_level;
// pwm_cnt, frame_start, step_tick, duty (8 x DUTY_W). Macro: LED_GAMMA_EN.
module led_pwm_sched
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ      = 27_000_000,
  parameter int PWM_HZ      = 1024,
  parameter int STEP_DIV    = 1_048_576,
  parameter int DUTY_W      = 16,
  parameter int BREATHE_INC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_level,
  output logic [DUTY_W-1:0]     pwm_cnt,
  output logic                  frame_start,
  output logic                  step_tick,
  output logic [8*DUTY_W-1:0]   duty
);

  localparam int PERIOD = period(CLK_HZ, PWM_HZ);
  localparam int STEP_W =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DUTY_W-1:0] CNT_LAST =
    DUTY_W'(PERIOD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(STEP_DIV - 1);
  localparam level_t INC     = LEVEL_W'(BREATHE_INC);
  localparam level_t LVL_MAX = '1;

  logic [STEP_W-1:0] step_cnt;
  logic              boundary;
  logic              xfer;
  logic              step_now;

  mode_e  mode_q, mode_n;
  level_t static_q, static_n;
  level_t brt_q, brt_n;
  logic   up_q, up_n;
  level_t rot_q [NCH];
  level_t rot_n [NCH];
  level_t lvl_n [NCH];

  logic [LEVEL_W:0] brt_up;

  logic step_pend_q;
  logic pend_vld_q;
  cfg_t pend_q;

  logic [DUTY_W-1:0]     duty_arr [NCH];
  logic [NCH*DUTY_W-1:0] duty_n;
  logic [NCH*DUTY_W-1:0] duty_q;

  assign boundary    = (pwm_cnt == CNT_LAST);
  assign frame_start = boundary;
  assign step_tick   = (step_cnt == STEP_LAST);
  assign cfg_ready   = ~pend_vld_q;
  assign xfer        = cfg_valid & cfg_ready;
  // A tick landing on the boundary counts for it
  assign step_now    = step_pend_q | step_tick;
  assign duty        = duty_q;
  assign brt_up      = {1'b0, brt_q} + {1'b0, INC};

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pwm_cnt  <= boundary
                ? '0 : pwm_cnt + DUTY_W'(1);
      step_cnt <= step_tick
                ? '0 : step_cnt + STEP_W'(1);
    end
  end

  // Pattern state as it will be after this boundary.
  // A pending config wins and swallows the step.
  always_comb begin
    mode_n   = mode_q;
    static_n = static_q;
    brt_n    = brt_q;
    up_n     = up_q;
    rot_n    = rot_q;
    if (pend_vld_q) begin
      mode_n   = pend_q.mode;
      static_n = pend_q.level;
      brt_n    = '0;
      up_n     = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        rot_n[i] = ROT_INIT[i*LEVEL_W +: LEVEL_W];
      end
    end else if (step_now) begin
      unique case (mode_q)
        MODE_ROTATE: begin
          rot_n[0] = rot_q[NCH-1];
          for (int i = 1; i < NCH; i++) begin
            rot_n[i] = rot_q[i-1];
          end
        end
        MODE_BREATHE: begin
          if (up_q) begin
            if (brt_up >= {1'b0, LVL_MAX}) begin
              brt_n = LVL_MAX;
              up_n  = 1'b0;
            end else begin
              brt_n = brt_up[LEVEL_W-1:0];
            end
          end else if (brt_q <= INC) begin
            brt_n = '0;
            up_n  = 1'b1;
          end else begin
            brt_n = brt_q - INC;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lvl_n[i] = '0;
      unique case (mode_n)
        MODE_OFF:     lvl_n[i] = '0;
        MODE_ROTATE:  lvl_n[i] = rot_n[i];
        MODE_BREATHE: lvl_n[i] = brt_n;
        MODE_STATIC:  lvl_n[i] = static_n;
        default:      lvl_n[i] = '0;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    led_duty_scale #(
      .DUTY_W (DUTY_W),
      .PERIOD (PERIOD)
    ) u_scale (
      .level (lvl_n[g]),
      .duty  (duty_arr[g])
    );
  end

  always_comb begin
    duty_n = '0;
    for (int i = 0; i < NCH; i++) begin
      duty_n[i*DUTY_W +: DUTY_W] = duty_arr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_ROTATE;
      static_q    <= '0;
      brt_q       <= '0;
      up_q        <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        rot_q[i] <= ROT_INIT[i*LEVEL_W +: LEVEL_W];
      end
      step_pend_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      duty_q      <= '0;
    end else begin
      if (boundary) begin
        mode_q      <= mode_n;
        static_q    <= static_n;
        brt_q       <= brt_n;
        up_q        <= up_n;
        rot_q       <= rot_n;
        duty_q      <= duty_n;
        step_pend_q <= 1'b0;
        pend_vld_q  <= 1'b0;
      end else if (step_tick) begin
        step_pend_q <= 1'b1;
      end
      // Slot is free here, so a boundary transfer
      // waits for the following boundary
      if (xfer) begin
        pend_q.mode  <= mode_e'(cfg_mode);
        pend_q.level <= cfg_level;
        pend_vld_q   <= 1'b1;
      end
    end
  end

endmodule
